// File: rtl/axi4_mem_pkg.sv
// Shared burst/response encodings, engine state types and beat-address helper for axi4_mem_responder.
// The WRAP arithmetic is always present; whether WRAP is legal is decided in the top (AXI4_MEM_WRAP_EN).
package axi4_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wr_state_e;

  function automatic logic [31:0] next_beat_addr(input logic [31:0] addr,
                                                 input logic [2:0]  size,
                                                 input logic [7:0]  len,
                                                 input logic [1:0]  burst);
    logic [31:0] step;
    logic [31:0] mask;
    logic [31:0] nxt;
    step = 32'd1 << size;
    mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      BURST_FIXED: nxt = addr;
      BURST_WRAP:  nxt = (addr & ~mask) | ((addr + step) & mask);
      default:     nxt = addr + step;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/axi4_mem_latency_cnt.sv
// Response-latency down-counter: i_start loads LAT-1, o_done flags the last idle cycle (terminal count 0).
// Only meaningful for LAT >= 1; the engines bypass it entirely when LAT is 0.
module axi4_mem_latency_cnt #(
  parameter int LAT = 5
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  output logic o_done
);

  localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT);
  localparam logic [CNT_W-1:0] LOAD = (LAT > 0) ? CNT_W'(LAT - 1) : '0;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 subordinate with internal word memory; independent read/write engines, one outstanding each.
// Optional WRAP burst support: define AXI4_MEM_WRAP_EN (otherwise WRAP is answered like a reserved burst).
//
// state  | meaning
// R_IDLE | arready high, waiting for AR
// R_WAIT | counting LAT idle cycles before the first R beat
// R_DATA | presenting R beats until the last one is accepted
// W_IDLE | awready high, W not accepted yet
// W_DATA | accepting exactly len+1 W beats
// W_WAIT | counting LAT idle cycles after the last W beat
// W_RESP | bvalid high until bready
module axi4_mem_responder
  import axi4_mem_pkg::*;
#(
  parameter int          AXI_DATA_WIDTH = 32,
  parameter int          AXI_ID_WIDTH   = 4,
  parameter int          AXI_USER_WIDTH = 4,
  parameter int          LAT            = 5,
  parameter int          MEM_DEPTH      = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arstn,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi4_arid,
  input  logic [31:0]                 s_axi4_araddr,
  input  logic [7:0]                  s_axi4_arlen,
  input  logic [2:0]                  s_axi4_arsize,
  input  logic [1:0]                  s_axi4_arburst,
  input  logic [AXI_USER_WIDTH-1:0]   s_axi4_aruser,
  input  logic                        s_axi4_arvalid,
  output logic                        s_axi4_arready,
  output logic [AXI_ID_WIDTH-1:0]     s_axi4_rid,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi4_rdata,
  output logic [1:0]                  s_axi4_rresp,
  output logic                        s_axi4_rlast,
  output logic [AXI_USER_WIDTH-1:0]   s_axi4_ruser,
  output logic                        s_axi4_rvalid,
  input  logic                        s_axi4_rready,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi4_awid,
  input  logic [31:0]                 s_axi4_awaddr,
  input  logic [7:0]                  s_axi4_awlen,
  input  logic [2:0]                  s_axi4_awsize,
  input  logic [1:0]                  s_axi4_awburst,
  input  logic [AXI_USER_WIDTH-1:0]   s_axi4_awuser,
  input  logic                        s_axi4_awvalid,
  output logic                        s_axi4_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi4_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb,
  input  logic                        s_axi4_wlast,
  input  logic                        s_axi4_wvalid,
  output logic                        s_axi4_wready,
  output logic [AXI_ID_WIDTH-1:0]     s_axi4_bid,
  output logic [1:0]                  s_axi4_bresp,
  output logic [AXI_USER_WIDTH-1:0]   s_axi4_buser,
  output logic                        s_axi4_bvalid,
  input  logic                        s_axi4_bready
);

  localparam int STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH * STRB_W);
`ifdef AXI4_MEM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  // Whole-burst error: oversize beats, reserved/unsupported burst type, illegal WRAP shape.
  function automatic logic burst_bad(input logic [31:0] addr, input logic [2:0] size,
                                     input logic [7:0] len, input logic [1:0] burst);
    logic bad;
    logic wrap_ok;
    wrap_ok = (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) &&
              ((addr & ((32'd1 << size) - 32'd1)) == 32'd0);
    bad = (size > 3'(ADDR_LSB));
    case (burst)
      BURST_FIXED, BURST_INCR: ;
      BURST_WRAP: if (!WRAP_EN || !wrap_ok) bad = 1'b1;
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic in_range(input logic [31:0] addr);
    logic [32:0] off;
    off = {1'b0, addr - BASE_ADDR};
    return (addr >= BASE_ADDR) && (off < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr - BASE_ADDR) >> ADDR_LSB;
    return off[IDX_W-1:0];
  endfunction

  logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // ---------------- read engine ----------------
  rd_state_e                 r_rstate, w_rstate_nxt;
  logic [AXI_ID_WIDTH-1:0]   r_ar_id;
  logic [31:0]               r_ar_addr;
  logic [7:0]                r_ar_len;
  logic [2:0]                r_ar_size;
  logic [1:0]                r_ar_burst;
  logic [AXI_USER_WIDTH-1:0] r_ar_user;
  logic                      r_ar_bad;
  logic [7:0]                r_rbeat;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                r_rresp;

  logic        w_ar_hs, w_r_hs, w_r_last, w_r_done, w_r_start;
  logic        w_rd_bad, w_rd_ok, w_rd_load;
  logic [31:0] w_r_next_addr, w_rd_addr;

  assign w_ar_hs       = s_axi4_arvalid && (r_rstate == R_IDLE);
  assign w_r_hs        = s_axi4_rready && (r_rstate == R_DATA);
  assign w_r_last      = (r_rbeat == r_ar_len);
  assign w_r_start     = w_ar_hs && (LAT != 0);
  assign w_r_next_addr = next_beat_addr(r_ar_addr, r_ar_size, r_ar_len, r_ar_burst);

  // Address whose data is captured into r_rdata at this edge (first beat or next beat).
  always_comb begin
    w_rd_addr = w_r_next_addr;
    w_rd_bad  = r_ar_bad;
    if (r_rstate == R_IDLE) begin
      w_rd_addr = s_axi4_araddr;
      w_rd_bad  = burst_bad(s_axi4_araddr, s_axi4_arsize, s_axi4_arlen, s_axi4_arburst);
    end else if (r_rstate == R_WAIT) begin
      w_rd_addr = r_ar_addr;
    end
  end

  assign w_rd_ok   = !w_rd_bad && in_range(w_rd_addr);
  assign w_rd_load = (w_ar_hs && (LAT == 0)) || ((r_rstate == R_WAIT) && w_r_done) ||
                     (w_r_hs && !w_r_last);

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (s_axi4_arvalid) w_rstate_nxt = (LAT == 0) ? R_DATA : R_WAIT;
      R_WAIT:  if (w_r_done) w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axi4_rready && w_r_last) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      r_rstate   <= R_IDLE;
      r_ar_id    <= '0;
      r_ar_addr  <= '0;
      r_ar_len   <= '0;
      r_ar_size  <= '0;
      r_ar_burst <= '0;
      r_ar_user  <= '0;
      r_ar_bad   <= 1'b0;
      r_rbeat    <= '0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_ar_id    <= s_axi4_arid;
        r_ar_addr  <= s_axi4_araddr;
        r_ar_len   <= s_axi4_arlen;
        r_ar_size  <= s_axi4_arsize;
        r_ar_burst <= s_axi4_arburst;
        r_ar_user  <= s_axi4_aruser;
        r_ar_bad   <= w_rd_bad;
        r_rbeat    <= '0;
      end else if (w_r_hs && !w_r_last) begin
        r_ar_addr <= w_r_next_addr;
        r_rbeat   <= r_rbeat + 8'd1;
      end
      // Captured with the pre-edge memory contents: a same-cycle write is seen by the next read.
      if (w_rd_load) begin
        r_rdata <= w_rd_ok ? r_mem[word_idx(w_rd_addr)] : '0;
        r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  axi4_mem_latency_cnt #(.LAT(LAT)) u_rd_lat (
    .i_clk   (axi4_aclk),
    .i_rst_n (axi4_arstn),
    .i_start (w_r_start),
    .o_done  (w_r_done)
  );

  assign s_axi4_arready = (r_rstate == R_IDLE);
  assign s_axi4_rvalid  = (r_rstate == R_DATA);
  assign s_axi4_rlast   = (r_rstate == R_DATA) && w_r_last;
  assign s_axi4_rid     = r_ar_id;
  assign s_axi4_ruser   = r_ar_user;
  assign s_axi4_rdata   = r_rdata;
  assign s_axi4_rresp   = r_rresp;

  // ---------------- write engine ----------------
  wr_state_e                 r_wstate, w_wstate_nxt;
  logic [AXI_ID_WIDTH-1:0]   r_aw_id;
  logic [31:0]               r_aw_addr;
  logic [7:0]                r_aw_len;
  logic [2:0]                r_aw_size;
  logic [1:0]                r_aw_burst;
  logic [AXI_USER_WIDTH-1:0] r_aw_user;
  logic                      r_aw_bad;
  logic                      r_werr;
  logic [7:0]                r_wbeat;

  logic             w_aw_hs, w_w_hs, w_w_last, w_w_done, w_w_start;
  logic             w_aw_bad, w_w_in_range, w_mem_we;
  logic [IDX_W-1:0] w_w_idx;

  assign w_aw_hs      = s_axi4_awvalid && (r_wstate == W_IDLE);
  assign w_w_hs       = s_axi4_wvalid && (r_wstate == W_DATA);
  assign w_w_last     = (r_wbeat == r_aw_len);
  assign w_w_start    = w_w_hs && w_w_last && (LAT != 0);
  assign w_aw_bad     = burst_bad(s_axi4_awaddr, s_axi4_awsize, s_axi4_awlen, s_axi4_awburst);
  assign w_w_in_range = in_range(r_aw_addr);
  assign w_mem_we     = w_w_hs && w_w_in_range && !r_aw_bad;
  assign w_w_idx      = word_idx(r_aw_addr);

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (s_axi4_awvalid) w_wstate_nxt = W_DATA;
      W_DATA:  if (s_axi4_wvalid && w_w_last) w_wstate_nxt = (LAT == 0) ? W_RESP : W_WAIT;
      W_WAIT:  if (w_w_done) w_wstate_nxt = W_RESP;
      W_RESP:  if (s_axi4_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      r_wstate   <= W_IDLE;
      r_aw_id    <= '0;
      r_aw_addr  <= '0;
      r_aw_len   <= '0;
      r_aw_size  <= '0;
      r_aw_burst <= '0;
      r_aw_user  <= '0;
      r_aw_bad   <= 1'b0;
      r_werr     <= 1'b0;
      r_wbeat    <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_aw_id    <= s_axi4_awid;
        r_aw_addr  <= s_axi4_awaddr;
        r_aw_len   <= s_axi4_awlen;
        r_aw_size  <= s_axi4_awsize;
        r_aw_burst <= s_axi4_awburst;
        r_aw_user  <= s_axi4_awuser;
        r_aw_bad   <= w_aw_bad;
        r_werr     <= w_aw_bad;
        r_wbeat    <= '0;
      end else if (w_w_hs) begin
        // wlast only flags errors; the beat count always follows awlen.
        if (!w_w_in_range || (s_axi4_wlast != w_w_last)) r_werr <= 1'b1;
        if (!w_w_last) begin
          r_aw_addr <= next_beat_addr(r_aw_addr, r_aw_size, r_aw_len, r_aw_burst);
          r_wbeat   <= r_wbeat + 8'd1;
        end
      end
    end
  end

  // Memory has no reset so contents survive axi4_arstn.
  always_ff @(posedge axi4_aclk) begin
    if (w_mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi4_wstrb[b]) r_mem[w_w_idx][8*b +: 8] <= s_axi4_wdata[8*b +: 8];
      end
    end
  end

  axi4_mem_latency_cnt #(.LAT(LAT)) u_wr_lat (
    .i_clk   (axi4_aclk),
    .i_rst_n (axi4_arstn),
    .i_start (w_w_start),
    .o_done  (w_w_done)
  );

  assign s_axi4_awready = (r_wstate == W_IDLE);
  assign s_axi4_wready  = (r_wstate == W_DATA);
  assign s_axi4_bvalid  = (r_wstate == W_RESP);
  assign s_axi4_bresp   = ((r_wstate == W_RESP) && r_werr) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi4_bid     = r_aw_id;
  assign s_axi4_buser   = r_aw_user;

endmodule
